// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate-extension unit: mode encodings and default widths.
// Purely combinational constants, no latency or backpressure of its own.
// Imported by imm_ext_core and imm_extend_pipe.
package imm_extend_pipe_pkg;

    typedef enum logic [1:0] {
        IMM_ZERO   = 2'b00,
        IMM_SIGN   = 2'b01,
        IMM_UPPER  = 2'b10,
        IMM_BRANCH = 2'b11
    } imm_mode_e;

    localparam int IMM_IN_W  = 16;
    localparam int IMM_OUT_W = 32;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender (zero / sign / upper / branch), shared with the jump-target path.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller owns all flow control.
module imm_ext_core
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    localparam int PAD = OUT_W - IN_W;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;

    assign zext = {{PAD{1'b0}}, imm};
    assign sext = {{PAD{imm[IN_W-1]}}, imm};

    always_comb begin
        ext = zext;
        unique case (imm_mode_e'(mode))
            IMM_ZERO:   ext = zext;
            IMM_SIGN:   ext = sext;
            IMM_UPPER:  ext = {imm, {PAD{1'b0}}};
            // Word-scaled offset: the two sign bits shifted out are dropped.
            IMM_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate extension for decode, buffered in a DEPTH-entry result FIFO (optional stats: IMM_EXT_STATS_EN).
// Latency: 1 cycle from accept to out_valid when the buffer is empty.
// Backpressure: valid/ready; in_ready is derived only from the registered count, so no path from out_ready.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [1:0]       out_mode
`ifdef IMM_EXT_STATS_EN
    ,
    output logic [15:0]      stat_xfers,
    output logic [15:0]      stat_stall
`endif
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    CNT_FULL = (PW+1)'(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [1:0]       mem_mode [DEPTH];
    logic [OUT_W-1:0] ext;
    logic             push;
    logic             pop;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (imm),
        .mode (mode),
        .ext  (ext)
    );

    assign in_ready  = (count != CNT_FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_data[rd_ptr];
    assign out_mode  = mem_mode[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Only entry 0 is cleared so the idle output reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_data[0] <= '0;
            mem_mode[0] <= '0;
        end else if (push) begin
            mem_data[wr_ptr] <= ext;
            mem_mode[wr_ptr] <= mode;
        end
    end

`ifdef IMM_EXT_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_xfers <= '0;
            stat_stall <= '0;
        end else begin
            if (push && stat_xfers != 16'hFFFF)
                stat_xfers <= stat_xfers + 16'd1;
            if (in_valid && !in_ready && stat_stall != 16'hFFFF)
                stat_stall <= stat_stall + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed vectors push expectations, a monitor pops and compares.
module tb_imm_extend_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] imm;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_mode;
`ifdef IMM_EXT_STATS_EN
    logic [15:0] stat_xfers;
    logic [15:0] stat_stall;
`endif

    int errors = 0;
    int checks = 0;
    logic [33:0] exp_q [$];

    always #5 clk = ~clk;

    imm_extend_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm       (imm),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_mode  (out_mode)
`ifdef IMM_EXT_STATS_EN
        ,
        .stat_xfers (stat_xfers),
        .stat_stall (stat_stall)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every cycle with out_valid the head must match; it pops only on a handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", {30'd0, out_mode, out_data}, 64'hDEAD);
            end else begin
                check("out_head", {30'd0, out_mode, out_data}, {30'd0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Presents one input starting just after the next rising edge and holds it until accepted.
    task automatic send(input logic [15:0] i, input logic [1:0] m, input logic [31:0] e);
        @(posedge clk); #1;
        in_valid = 1'b1;
        imm      = i;
        mode     = m;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({m, e});
                return;
            end
        end
        check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        in_valid = 1'b0;
        imm      = 16'hA5A5;
        mode     = 2'b11;
    endtask

    task automatic drain();
        for (int n = 0; n < 60 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        imm       = 16'h0;
        mode      = 2'b00;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1. reset / idle
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_data",  64'(out_data),  64'd0);
`ifdef IMM_EXT_STATS_EN
        check("rst_stat_xfers", 64'(stat_xfers), 64'd0);
`endif

        // 2. single-cycle latency, sign then zero
        send(16'h80FF, 2'b01, 32'hFFFF80FF);
        idle_in();
        @(negedge clk);
        check("latency_valid", 64'(out_valid), 64'd1);
        send(16'h80FF, 2'b00, 32'h000080FF);
        // 3. upper and branch back-to-back
        send(16'h1234, 2'b10, 32'h12340000);
        send(16'hFFFF, 2'b11, 32'hFFFFFFFC);
        send(16'h4000, 2'b11, 32'h00010000);
        idle_in();
        drain();

        // 4. full buffer stalls the third input; outputs held while out_ready is low
        @(posedge clk); #1 out_ready = 1'b0;
        send(16'h0001, 2'b01, 32'h00000001);
        send(16'h0002, 2'b01, 32'h00000002);
        @(posedge clk); #1 imm = 16'h0003;
        @(negedge clk);
        check("full_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("full_hold_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back({2'b01, 32'h00000003});
                break;
            end
        end
        idle_in();
        drain();

        // 5. streaming at count=1 with pointer wrap
        @(posedge clk); #1 out_ready = 1'b0;
        send(16'h0100, 2'b00, 32'h00000100);
        @(posedge clk); #1 out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic [15:0] v;
            v = 16'hF000 + 16'(k);
            if (k != 0) begin
                @(posedge clk); #1;
            end
            imm  = v;
            mode = 2'b01;
            @(negedge clk);
            check("stream_in_ready",  64'(in_ready),  64'd1);
            check("stream_out_valid", 64'(out_valid), 64'd1);
            if (in_ready) exp_q.push_back({2'b01, {16'hFFFF, v}});
        end
        idle_in();
        drain();

        // 6. reset while full discards buffered data
        @(posedge clk); #1 out_ready = 1'b0;
        send(16'h0AAA, 2'b00, 32'h00000AAA);
        send(16'h0BBB, 2'b00, 32'h00000BBB);
        idle_in();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check("rst_full_out_valid", 64'(out_valid), 64'd0);
        check("rst_full_in_ready",  64'(in_ready),  64'd1);
        check("rst_full_out_data",  64'({out_mode, out_data}), 64'd0);
`ifdef IMM_EXT_STATS_EN
        check("rst_full_stat_xfers", 64'(stat_xfers), 64'd0);
`endif
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
